// File: rtl/alu_exec_unit_pkg.sv
// Encodings shared between the ALU control decoder and the execute unit.
package alu_exec_unit_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  localparam logic [1:0] SRC_ALU   = 2'b00;
  localparam logic [1:0] SRC_SHIFT = 2'b01;
  localparam logic [1:0] SRC_LUI   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // Only a subtract routed to the result drives the branch decision.
  function automatic logic is_branch_op(input logic [1:0] src, input logic [3:0] op);
    return (src == SRC_ALU) && (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_exec_unit_serial_sra_shifter.sv
// Iterative arithmetic right shifter: one bit per step, counting the amount down.
module serial_sra_shifter #(
  parameter int DATA_W = 32,
  parameter int SH_W   = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [SH_W-1:0]   amount_i,
  output logic              last_o,
  output logic [DATA_W-1:0] next_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic [SH_W-1:0]   count_q, count_d;

  assign next_o = DATA_W'($signed(data_q) >>> 1);
  assign last_o = (count_q == SH_W'(1));

  always_comb begin
    data_d  = data_q;
    count_d = count_q;
    if (load_i) begin
      data_d  = data_i;
      count_d = amount_i;
    end else if (step_i && (count_q != '0)) begin
      data_d  = next_o;
      count_d = count_q - SH_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with start/done handshake; sra/srav take amount+1 cycles.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SH_W   = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [3:0]        ALUCtrl_i,
  input  logic [1:0]        fur_slt_i,
  input  logic              sra_scr_i,
  input  logic              be_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  input  logic [SH_W-1:0]   shamt_i,
  input  logic [15:0]       imm_i,
  output logic              ready_o,
  output logic              done_o,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              branch_o
);

  state_e            state_q;
  logic              ready_q;
  logic              done_q;
  logic [DATA_W-1:0] result_q;
  logic              zero_q;
  logic              branch_q;

  logic              accept;
  logic              is_shift;
  logic [SH_W-1:0]   sh_amt;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] fast_res;
  logic              fast_branch;
  logic              sh_last;
  logic [DATA_W-1:0] sh_next;

  assign accept   = start_i & ready_q;
  assign is_shift = (fur_slt_i == SRC_SHIFT);
  assign sh_amt   = sra_scr_i ? src1_i[SH_W-1:0] : shamt_i;

  always_comb begin
    alu_res = '0;
    case (ALUCtrl_i)
      ALU_AND:  alu_res = src1_i & src2_i;
      ALU_OR:   alu_res = src1_i | src2_i;
      ALU_ADD:  alu_res = src1_i + src2_i;
      ALU_SUB:  alu_res = src1_i - src2_i;
      ALU_SLT:  alu_res = {{(DATA_W-1){1'b0}}, $signed(src1_i) < $signed(src2_i)};
      ALU_SLTU: alu_res = {{(DATA_W-1){1'b0}}, src1_i < src2_i};
      default:  alu_res = '0;
    endcase
  end

  // Single-cycle result; a zero-amount shift just passes the operand through.
  always_comb begin
    fast_res = '0;
    case (fur_slt_i)
      SRC_ALU:   fast_res = alu_res;
      SRC_SHIFT: fast_res = src2_i;
      SRC_LUI:   fast_res = {imm_i, {(DATA_W-16){1'b0}}};
      default:   fast_res = '0;
    endcase
  end

  assign fast_branch = is_branch_op(fur_slt_i, ALUCtrl_i) & ((fast_res == '0) ^ be_i);

  serial_sra_shifter #(
    .DATA_W (DATA_W),
    .SH_W   (SH_W)
  ) u_shifter (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (accept & is_shift),
    .step_i   (state_q == ST_SHIFT),
    .data_i   (src2_i),
    .amount_i (sh_amt),
    .last_o   (sh_last),
    .next_o   (sh_next)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      branch_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            ready_q <= 1'b0;
            if (is_shift && (sh_amt != '0)) begin
              state_q <= ST_SHIFT;
            end else begin
              state_q  <= ST_DONE;
              done_q   <= 1'b1;
              result_q <= fast_res;
              zero_q   <= (fast_res == '0);
              branch_q <= fast_branch;
            end
          end
        end
        ST_SHIFT: begin
          if (sh_last) begin
            state_q  <= ST_DONE;
            done_q   <= 1'b1;
            result_q <= sh_next;
            zero_q   <= (sh_next == '0);
            branch_q <= 1'b0;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o  = ready_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign zero_o   = zero_q;
  assign branch_o = branch_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench: directed table, corner sequences, randomized ops vs reference model.
module tb_alu_exec_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [3:0]  ALUCtrl_i;
  logic [1:0]  fur_slt_i;
  logic        sra_scr_i;
  logic        be_i;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic [4:0]  shamt_i;
  logic [15:0] imm_i;
  logic        ready_o;
  logic        done_o;
  logic [31:0] result_o;
  logic        zero_o;
  logic        branch_o;

  int n_cmp  = 0;
  int n_miss = 0;

  always #5 clk_i = ~clk_i;

  alu_exec_unit dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .ALUCtrl_i (ALUCtrl_i),
    .fur_slt_i (fur_slt_i),
    .sra_scr_i (sra_scr_i),
    .be_i      (be_i),
    .src1_i    (src1_i),
    .src2_i    (src2_i),
    .shamt_i   (shamt_i),
    .imm_i     (imm_i),
    .ready_o   (ready_o),
    .done_o    (done_o),
    .result_o  (result_o),
    .zero_o    (zero_o),
    .branch_o  (branch_o)
  );

  typedef struct {
    logic [3:0]  ctrl;
    logic [1:0]  fur;
    logic        scr;
    logic        be;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [4:0]  sh;
    logic [15:0] imm;
    logic [31:0] exp_res;
    logic        exp_zero;
    logic        exp_br;
    int          exp_lat;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic scramble();
    ALUCtrl_i = 4'($urandom);
    fur_slt_i = 2'($urandom);
    sra_scr_i = 1'($urandom);
    be_i      = 1'($urandom);
    src1_i    = $urandom;
    src2_i    = $urandom;
    shamt_i   = 5'($urandom);
    imm_i     = 16'($urandom);
  endtask

  // Reference model: operation semantics straight from the instruction definitions.
  function automatic void model(input logic [3:0] ctrl, input logic [1:0] fur, input logic scr,
                                input logic be, input logic [31:0] s1, input logic [31:0] s2,
                                input logic [4:0] sh, input logic [15:0] imm,
                                output logic [31:0] r, output logic br, output int lat);
    int amt;
    r   = 32'h0;
    br  = 1'b0;
    lat = 1;
    case (fur)
      2'd0: begin
        case (ctrl)
          4'd0:  r = s1 & s2;
          4'd1:  r = s1 | s2;
          4'd2:  r = s1 + s2;
          4'd6:  r = s1 - s2;
          4'd7:  r = ($signed(s1) < $signed(s2)) ? 32'd1 : 32'd0;
          4'd15: r = (s1 < s2) ? 32'd1 : 32'd0;
          default: r = 32'h0;
        endcase
        if (ctrl == 4'd6) br = (r == 32'h0) ^ be;
      end
      2'd1: begin
        amt = scr ? int'(s1 % 32) : int'(sh);
        r   = 32'($signed(s2) >>> amt);
        lat = amt + 1;
      end
      2'd2: r = {imm, 16'h0000};
      default: r = 32'h0;
    endcase
  endfunction

  task automatic do_op(input logic [3:0] ctrl, input logic [1:0] fur, input logic scr,
                       input logic be, input logic [31:0] s1, input logic [31:0] s2,
                       input logic [4:0] sh, input logic [15:0] imm,
                       output logic [31:0] res, output logic z, output logic br, output int lat);
    int guard = 0;
    while (!ready_o && guard < 40) begin
      tick();
      guard++;
    end
    check("ready_before_start", 32'(ready_o), 32'd1);
    ALUCtrl_i = ctrl; fur_slt_i = fur; sra_scr_i = scr; be_i = be;
    src1_i = s1; src2_i = s2; shamt_i = sh; imm_i = imm;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    scramble();
    lat = 1;
    while (!done_o && lat < 40) begin
      tick();
      lat++;
    end
    if (!done_o) lat = -1;
    res = result_o;
    z   = zero_o;
    br  = branch_o;
    check("ready_low_in_done", 32'(ready_o), 32'd0);
    tick();
    check("done_single_pulse", 32'(done_o), 32'd0);
    $display("op fur=%0d ctrl=%h s1=%h s2=%h -> res=%h z=%0d br=%0d lat=%0d",
             fur, ctrl, s1, s2, res, z, br, lat);
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] res, exp_r;
    logic        z, br, exp_b;
    int          lat, exp_l, cyc, pulses;
    logic [3:0]  ops[6];
    vec_t        v;

    ops = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hF};
    //          ctrl  fur  scr  be   s1            s2            sh     imm        res           z     br    lat
    vecs.push_back('{4'h2, 2'd0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000002, 5'd0,  16'h0,     32'h00000001, 1'b0, 1'b0, 1});
    vecs.push_back('{4'h6, 2'd0, 1'b0, 1'b1, 32'd5,        32'd7,        5'd0,  16'h0,     32'hFFFFFFFE, 1'b0, 1'b1, 1});
    vecs.push_back('{4'h6, 2'd0, 1'b0, 1'b0, 32'h1234,     32'h1234,     5'd0,  16'h0,     32'h00000000, 1'b1, 1'b1, 1});
    vecs.push_back('{4'h6, 2'd0, 1'b0, 1'b1, 32'h1234,     32'h1234,     5'd0,  16'h0,     32'h00000000, 1'b1, 1'b0, 1});
    vecs.push_back('{4'h7, 2'd0, 1'b0, 1'b0, 32'h80000000, 32'd1,        5'd0,  16'h0,     32'h00000001, 1'b0, 1'b0, 1});
    vecs.push_back('{4'hF, 2'd0, 1'b0, 1'b0, 32'h80000000, 32'd1,        5'd0,  16'h0,     32'h00000000, 1'b1, 1'b0, 1});
    vecs.push_back('{4'h0, 2'd0, 1'b0, 1'b0, 32'h0000F0F0, 32'h0000FF00, 5'd0,  16'h0,     32'h0000F000, 1'b0, 1'b0, 1});
    vecs.push_back('{4'h1, 2'd0, 1'b0, 1'b0, 32'h0000F0F0, 32'h0000FF00, 5'd0,  16'h0,     32'h0000FFF0, 1'b0, 1'b0, 1});
    vecs.push_back('{4'h0, 2'd1, 1'b0, 1'b0, 32'h0,        32'hF0000000, 5'd4,  16'h0,     32'hFF000000, 1'b0, 1'b0, 5});
    vecs.push_back('{4'h0, 2'd1, 1'b1, 1'b0, 32'h00000020, 32'h80000001, 5'd9,  16'h0,     32'h80000001, 1'b0, 1'b0, 1});
    vecs.push_back('{4'h0, 2'd1, 1'b1, 1'b0, 32'hFFFFFFE3, 32'h80000000, 5'd0,  16'h0,     32'hF0000000, 1'b0, 1'b0, 4});
    vecs.push_back('{4'h0, 2'd1, 1'b0, 1'b0, 32'h0,        32'h80000000, 5'd31, 16'h0,     32'hFFFFFFFF, 1'b0, 1'b0, 32});
    vecs.push_back('{4'h0, 2'd1, 1'b0, 1'b0, 32'h0,        32'h7FFFFFFF, 5'd31, 16'h0,     32'h00000000, 1'b1, 1'b0, 32});
    vecs.push_back('{4'h6, 2'd2, 1'b0, 1'b1, 32'd1,        32'd2,        5'd0,  16'hABCD,  32'hABCD0000, 1'b0, 1'b0, 1});
    vecs.push_back('{4'h2, 2'd3, 1'b0, 1'b1, 32'd5,        32'd5,        5'd0,  16'h1111,  32'h00000000, 1'b1, 1'b0, 1});
    vecs.push_back('{4'h3, 2'd0, 1'b0, 1'b1, 32'd5,        32'd9,        5'd0,  16'h0,     32'h00000000, 1'b1, 1'b0, 1});

    rst_i = 1'b1;
    start_i = 1'b0;
    scramble();
    repeat (3) tick();
    rst_i = 1'b0;
    check("reset_ready", 32'(ready_o), 32'd1);
    check("reset_done", 32'(done_o), 32'd0);
    check("reset_result", result_o, 32'h0);
    check("reset_zero", 32'(zero_o), 32'd1);
    check("reset_branch", 32'(branch_o), 32'd0);

    foreach (vecs[i]) begin
      v = vecs[i];
      do_op(v.ctrl, v.fur, v.scr, v.be, v.s1, v.s2, v.sh, v.imm, res, z, br, lat);
      check($sformatf("vec%0d_result", i), res, v.exp_res);
      check($sformatf("vec%0d_zero", i), 32'(z), 32'(v.exp_zero));
      check($sformatf("vec%0d_branch", i), 32'(br), 32'(v.exp_br));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(v.exp_lat));
    end

    // start_i pulsed while shifting must be neither accepted nor queued.
    ALUCtrl_i = 4'h0; fur_slt_i = 2'd1; sra_scr_i = 1'b0; be_i = 1'b0;
    src1_i = 32'h0; src2_i = 32'h80000000; shamt_i = 5'd8; imm_i = 16'h0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    lat = 1;
    while (!done_o && lat < 40) begin
      if (lat == 3) begin
        start_i = 1'b1; fur_slt_i = 2'd0; ALUCtrl_i = 4'h2; src1_i = 32'd1; src2_i = 32'd1;
      end else begin
        start_i = 1'b0;
      end
      tick();
      lat++;
    end
    start_i = 1'b0;
    check("busy_start_latency", 32'(lat), 32'd9);
    check("busy_start_result", result_o, 32'hFF800000);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (done_o) pulses++;
    end
    check("busy_start_no_queue", 32'(pulses), 32'd0);
    $display("op busy-start sequence lat=%0d res=%h", lat, result_o);

    // Reset in cycle 5 of a 21-cycle sra discards it without a done pulse.
    fur_slt_i = 2'd1; sra_scr_i = 1'b0; src2_i = 32'h12345678; shamt_i = 5'd20;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    pulses = 0;
    for (cyc = 1; cyc < 5; cyc++) begin
      tick();
      if (done_o) pulses++;
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("midreset_ready", 32'(ready_o), 32'd1);
    check("midreset_result", result_o, 32'h0);
    check("midreset_zero", 32'(zero_o), 32'd1);
    check("midreset_branch", 32'(branch_o), 32'd0);
    for (int k = 0; k < 30; k++) begin
      if (done_o) pulses++;
      tick();
    end
    check("midreset_no_done", 32'(pulses), 32'd0);
    $display("op mid-operation reset sequence done_pulses=%0d", pulses);

    for (int n = 0; n < 250; n++) begin
      v.fur  = ($urandom_range(0, 3) == 0) ? 2'd1 : 2'($urandom);
      v.ctrl = ($urandom_range(0, 7) == 0) ? 4'($urandom) : ops[$urandom_range(0, 5)];
      v.scr  = 1'($urandom);
      v.be   = 1'($urandom);
      case ($urandom_range(0, 4))
        0: v.s1 = 32'h80000000;
        1: v.s1 = 32'h7FFFFFFF;
        2: v.s1 = 32'hFFFFFFFF;
        default: v.s1 = $urandom;
      endcase
      v.s2  = ($urandom_range(0, 3) == 0) ? v.s1 : $urandom;
      v.sh  = 5'($urandom);
      v.imm = 16'($urandom);
      model(v.ctrl, v.fur, v.scr, v.be, v.s1, v.s2, v.sh, v.imm, exp_r, exp_b, exp_l);
      do_op(v.ctrl, v.fur, v.scr, v.be, v.s1, v.s2, v.sh, v.imm, res, z, br, lat);
      check("rand_result", res, exp_r);
      check("rand_zero", 32'(z), 32'(exp_r == 32'h0));
      check("rand_branch", 32'(br), 32'(exp_b));
      check("rand_latency", 32'(lat), 32'(exp_l));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage consumer of the ALU control bundle: ALUCtrl, fur_slt, sra_scr, be.
- Performs the selected operation on register/immediate operands.
- Generates result, zero and branch-taken outputs.
- Arithmetic right shifts (sra/srav) use an iterative 1-bit-per-cycle shifter, so every operation goes through a start/done handshake and the block is ready for the multi-cycle CPU.

Parameters:
- DATA_W, 32, operand/result width.
- SH_W, 5, shift-amount width; must equal log2(DATA_W).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  operation request; accepted only when ready_o=1.
- ALUCtrl_i  in  4  ALU op: 0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt (signed), 1111 sltu.
- fur_slt_i  in  2  result source: 00 ALU, 01 shifter, 10 lui, 11 reserved.
- sra_scr_i  in  1  shift-amount source: 0 = shamt_i (sra), 1 = src1_i[SH_W-1:0] (srav).
- be_i  in  1  branch sense: 0 = beq, 1 = bne.
- src1_i  in  DATA_W  rs operand.
- src2_i  in  DATA_W  rt operand or sign-extended immediate.
- shamt_i  in  SH_W  instruction shamt field.
- imm_i  in  16  immediate for lui.
- ready_o  out  1  high in IDLE only.
- done_o  out  1  one-cycle pulse when result_o, zero_o and branch_o are valid.
- result_o  out  DATA_W  registered result; holds its value until the next done_o.
- zero_o  out  1  result_o == 0.
- branch_o  out  1  zero_o XOR be_i (latched at start); forced 0 unless fur_slt=00 and ALUCtrl=0110.

Behaviour:
- Reset (rst_i=1 at a clock edge): state=IDLE, ready_o=1, done_o=0, result_o=0, zero_o=1, branch_o=0, shift count=0.
- Reset mid-operation discards the operation, with no done_o pulse.
- All control inputs and operands are captured on the accepting edge (start_i & ready_o). Later input changes have no effect.
- start_i outside IDLE is ignored; it is neither queued nor an error.
- FSM states: IDLE, SHIFT, DONE.
- IDLE + start, fur_slt in {00, 10, 11}:
  - compute combinationally from captured values, register the result, go to DONE;
  - done_o is asserted the cycle after acceptance (latency 1).
- IDLE + start, fur_slt=01:
  - load shift register = src2_i;
  - count = shamt_i if sra_scr_i=0, else src1_i[4:0];
  - count=0 goes straight to DONE (latency 1); otherwise go to SHIFT.
- SHIFT: each cycle the shift register is arithmetically right-shifted by 1 (MSB replicated) and count decrements. When count reaches 1, that shift is the last and the next state is DONE. Latency = amount+1 cycles, max 32 for an amount of 31.
- DONE: done_o=1 for exactly one cycle, result_o/zero_o/branch_o updated in that cycle, next state IDLE. ready_o is 0 in SHIFT and DONE, so the minimum issue interval is 2 cycles.
- ALU arithmetic:
  - add/sub wrap modulo 2^DATA_W; no overflow flag (addu/subu semantics).
  - slt is a signed compare, sltu unsigned; result is 0 or 1, zero-extended.
- lui: result = {imm_i, 16'b0}.
- fur_slt=11, or an unlisted ALUCtrl code: result 0, zero_o=1, branch_o=0, normal 1-cycle latency.
- Boundary cases:
  - srav uses only src1[4:0]; upper bits are ignored.
  - Shift by 31 of a negative value gives all ones; of a positive value gives 0.

Decomposition:
- Shared package holds:
  - ALU op constants: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU;
  - result-source constants: SRC_ALU, SRC_SHIFT, SRC_LUI;
  - FSM state encodings.
- These are shared with the ALU control decoder so both ends agree on encodings.
- One natural sub-module: serial_sra_shifter, holding the shift register, down-counter, load/step/last signals and arithmetic shift.
- The FSM, ALU datapath and output registers stay in the top module.

Test Plan:
- Reset mid-operation: start sra with shamt=20, assert rst_i in cycle 5 -> no done_o; ready_o=1 next cycle; result_o=0; zero_o=1.
- Add wrap: ALUCtrl=0010, src1=0xFFFFFFFF, src2=0x00000002 -> done_o 1 cycle later; result_o=0x00000001; zero_o=0.
- Branch, bne taken: ALUCtrl=0110, be=1, src1=5, src2=7 -> result_o=0xFFFFFFFE, zero_o=0, branch_o=1.
- Branch, beq taken: ALUCtrl=0110, be=0, src1=src2=0x1234 -> zero_o=1, branch_o=1.
- Signed vs unsigned compare, with src1=0x80000000, src2=1:
  - slt -> result_o=1;
  - sltu -> result_o=0.
- Shifts:
  - sra: shamt=4, src2=0xF0000000 -> done_o exactly 5 cycles after acceptance, result_o=0xFF000000.
  - srav: src1=0x00000020 (amount 0), src2=0x80000001 -> latency 1, result_o=0x80000001.
  - start_i pulsed during SHIFT -> ignored.
- lui: imm=0xABCD -> result_o=0xABCD0000.
- fur_slt=11 -> result_o=0 after 1 cycle.
